// File: rtl/sram_1w1r_fifo_ctrl.sv
// FWFT FIFO controller using an external 1W1R SRAM macro as storage, with a 2-entry output skid buffer.
// Optional FIFO_LEVEL_EN adds the level and almost_full outputs.
module sram_1w1r_fifo_ctrl #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 6,
   parameter int DEPTH        = 40,
   parameter int NUM_WMASKS   = 2,
   parameter int AFULL_THRESH = 36
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  sram_csb0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH+3)-1:0] level,
   output logic                       almost_full
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      sram_cnt;
   logic                  run_q;
   logic                  vld_p1;
   logic [1:0]            skid_cnt_p2;
   logic [DATA_WIDTH-1:0] skid0_p2, skid1_p2;
   logic                  push, pop, issue;
   logic [2:0]            occ;

   // Pointers cover a non-power-of-two macro, so wrap explicitly.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = run_q && (sram_cnt < CNT_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign out_valid = (skid_cnt_p2 != 2'd0);
   assign out_data  = skid0_p2;
   assign pop       = out_valid && out_ready;
   assign occ       = 3'(skid_cnt_p2) + 3'(vld_p1);
   assign issue     = (sram_cnt != '0) && (occ < (3'd2 + 3'(pop)));

   assign sram_csb0   = ~push;
   assign sram_addr0  = wr_ptr;
   assign sram_din0   = push ? in_data : '0;
   assign sram_wmask0 = push ? '1 : '0;
   assign sram_csb1   = ~issue;
   assign sram_addr1  = rd_ptr;

   // p0: pointers, macro occupancy and read issue
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         run_q    <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         sram_cnt <= '0;
         vld_p1   <= 1'b0;
      end else begin
         run_q  <= 1'b1;
         vld_p1 <= issue;
         if (push)  wr_ptr <= ptr_inc(wr_ptr);
         if (issue) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, issue})
            2'b10:   sram_cnt <= sram_cnt + 1'b1;
            2'b01:   sram_cnt <= sram_cnt - 1'b1;
            default: sram_cnt <= sram_cnt;
         endcase
      end
   end

   // p2: macro read data lands in the skid buffer; head is out_data
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         skid_cnt_p2 <= 2'd0;
         skid0_p2    <= '0;
         skid1_p2    <= '0;
      end else begin
         case ({vld_p1, pop})
            2'b10: begin
               if (skid_cnt_p2 == 2'd0) skid0_p2 <= sram_dout1;
               else                     skid1_p2 <= sram_dout1;
               skid_cnt_p2 <= skid_cnt_p2 + 2'd1;
            end
            2'b01: begin
               skid0_p2    <= skid1_p2;
               skid_cnt_p2 <= skid_cnt_p2 - 2'd1;
            end
            2'b11: begin
               if (skid_cnt_p2 == 2'd1) begin
                  skid0_p2 <= sram_dout1;
               end else begin
                  skid0_p2 <= skid1_p2;
                  skid1_p2 <= sram_dout1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FIFO_LEVEL_EN
   localparam int LVL_W = $clog2(DEPTH + 3);
   assign level       = LVL_W'(sram_cnt) + LVL_W'(vld_p1) + LVL_W'(skid_cnt_p2);
   assign almost_full = (level >= LVL_W'(AFULL_THRESH));
`endif

endmodule
